// File: rtl/preset_countdown_fsm_if.sv
// rtl/preset_countdown_fsm_if.sv - button/tick inputs and BCD display outputs of the preset countdown
interface preset_countdown_fsm_if;
  logic       mode_pressed;
  logic       start_pressed;
  logic       tick;
  logic [1:0] mode_idx;
  logic [3:0] value_digit0;
  logic [3:0] value_digit1;
  logic [3:0] value_digit2;
  logic       running;
  logic       done;

  modport master (
    output mode_pressed, start_pressed, tick,
    input  mode_idx, value_digit0, value_digit1, value_digit2, running, done
  );

  modport slave (
    input  mode_pressed, start_pressed, tick,
    output mode_idx, value_digit0, value_digit1, value_digit2, running, done
  );
endinterface

// File: rtl/preset_countdown_fsm.sv
// rtl/preset_countdown_fsm.sv - selectable BCD preset with start/pause countdown on a 1 Hz tick
module preset_countdown_fsm #(
  parameter int          NUM_MODES = 4,
  parameter logic [11:0] PRESET_0  = 12'h030,
  parameter logic [11:0] PRESET_1  = 12'h060,
  parameter logic [11:0] PRESET_2  = 12'h090,
  parameter logic [11:0] PRESET_3  = 12'h120
) (
  input logic                  clk,
  input logic                  rst_p,
  preset_countdown_fsm_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t      state_q;
  logic [1:0]  mode_idx_q;
  logic [11:0] count_q;
  logic        running_q;
  logic        done_q;

  logic [1:0]  mode_inc_d;
  logic [11:0] count_dec_d;

  function automatic logic [11:0] preset_of(input logic [1:0] idx);
    case (idx)
      2'd0:    preset_of = PRESET_0;
      2'd1:    preset_of = PRESET_1;
      2'd2:    preset_of = PRESET_2;
      default: preset_of = PRESET_3;
    endcase
  endfunction

  assign mode_inc_d = (mode_idx_q == 2'(NUM_MODES - 1)) ? 2'd0 : mode_idx_q + 2'd1;

  // RUN never holds 000, so the hundreds borrow cannot wrap below zero.
  always_comb begin
    count_dec_d = count_q;
    if (count_q[3:0] != 4'd0) begin
      count_dec_d[3:0] = count_q[3:0] - 4'd1;
    end else begin
      count_dec_d[3:0] = 4'd9;
      if (count_q[7:4] != 4'd0) begin
        count_dec_d[7:4] = count_q[7:4] - 4'd1;
      end else begin
        count_dec_d[7:4]  = 4'd9;
        count_dec_d[11:8] = count_q[11:8] - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state_q    <= S_IDLE;
      mode_idx_q <= 2'd0;
      count_q    <= PRESET_0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_pressed) begin
            if (count_q != 12'h000) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else if (bus.mode_pressed) begin
            mode_idx_q <= mode_inc_d;
            count_q    <= preset_of(mode_inc_d);
          end
        end
        S_RUN: begin
          if (bus.tick) begin
            count_q <= count_dec_d;
            if (count_dec_d == 12'h000) begin
              state_q   <= S_DONE;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end else if (bus.start_pressed) begin
              state_q   <= S_PAUSE;
              running_q <= 1'b0;
            end
          end else if (bus.start_pressed) begin
            state_q   <= S_PAUSE;
            running_q <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (bus.start_pressed) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end else if (bus.mode_pressed) begin
            state_q <= S_IDLE;
            count_q <= preset_of(mode_idx_q);
          end
        end
        S_DONE: begin
          if (bus.start_pressed) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            count_q <= preset_of(mode_idx_q);
          end else if (bus.mode_pressed) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            mode_idx_q <= mode_inc_d;
            count_q    <= preset_of(mode_inc_d);
          end
        end
        default: begin
          state_q   <= S_IDLE;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mode_idx     = mode_idx_q;
  assign bus.value_digit0 = count_q[3:0];
  assign bus.value_digit1 = count_q[7:4];
  assign bus.value_digit2 = count_q[11:8];
  assign bus.running      = running_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_preset_countdown_fsm.sv
// tb/tb_preset_countdown_fsm.sv - scoreboard bench for preset_countdown_fsm (4-mode and 2-mode builds)
module tb_preset_countdown_fsm;

  logic clk = 1'b0;
  logic rst_p = 1'b0;
  always #5 clk = ~clk;

  preset_countdown_fsm_if ifc_a ();
  preset_countdown_fsm_if ifc_b ();

  preset_countdown_fsm dut_a (
    .clk   (clk),
    .rst_p (rst_p),
    .bus   (ifc_a.slave)
  );

  preset_countdown_fsm #(.NUM_MODES(2)) dut_b (
    .clk   (clk),
    .rst_p (rst_p),
    .bus   (ifc_b.slave)
  );

  typedef struct {
    bit          sel;
    string       nm;
    logic [1:0]  m;
    logic [11:0] d;
    logic        r;
    logic        dn;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic cyc(input bit r, input bit m, input bit s, input bit t);
    @(negedge clk);
    rst_p               = r;
    ifc_a.mode_pressed  = m;
    ifc_a.start_pressed = s;
    ifc_a.tick          = t;
    ifc_b.mode_pressed  = m;
    ifc_b.start_pressed = s;
    ifc_b.tick          = t;
    @(posedge clk);
  endtask

  task automatic push(input bit sel, input string nm, input logic [1:0] m,
                      input logic [11:0] d, input logic r, input logic dn);
    exp_t e;
    e.sel = sel; e.nm = nm; e.m = m; e.d = d; e.r = r; e.dn = dn;
    sb_q.push_back(e);
  endtask

  // Each expectation is pushed right after the edge it describes and checked on the next falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      logic [1:0]  am;
      logic [11:0] ad;
      logic        ar, adn;
      e = sb_q.pop_front();
      if (e.sel) begin
        am = ifc_b.mode_idx; ad = {ifc_b.value_digit2, ifc_b.value_digit1, ifc_b.value_digit0};
        ar = ifc_b.running;  adn = ifc_b.done;
      end else begin
        am = ifc_a.mode_idx; ad = {ifc_a.value_digit2, ifc_a.value_digit1, ifc_a.value_digit0};
        ar = ifc_a.running;  adn = ifc_a.done;
      end
      n_cmp++;
      if ({am, ad, ar, adn} !== {e.m, e.d, e.r, e.dn}) begin
        n_err++;
        $display("FAIL %s: got mode=%0d digits=%h run=%b done=%b, want mode=%0d digits=%h run=%b done=%b",
                 e.nm, am, ad, ar, adn, e.m, e.d, e.r, e.dn);
      end
    end
  end

  initial begin
    ifc_a.mode_pressed = 1'b0; ifc_a.start_pressed = 1'b0; ifc_a.tick = 1'b0;
    ifc_b.mode_pressed = 1'b0; ifc_b.start_pressed = 1'b0; ifc_b.tick = 1'b0;

    cyc(1, 0, 0, 0); push(0, "reset", 0, 12'h030, 0, 0); push(1, "reset_b", 0, 12'h030, 0, 0);
    cyc(0, 0, 0, 1); push(0, "idle_tick", 0, 12'h030, 0, 0);

    cyc(0, 1, 0, 0); push(0, "mode1", 1, 12'h060, 0, 0); push(1, "mode1_b", 1, 12'h060, 0, 0);
    cyc(0, 1, 0, 0); push(0, "mode2", 2, 12'h090, 0, 0); push(1, "wrap_b", 0, 12'h030, 0, 0);
    cyc(0, 1, 0, 0); push(0, "mode3", 3, 12'h120, 0, 0);
    cyc(0, 1, 0, 0); push(0, "wrap", 0, 12'h030, 0, 0);

    cyc(0, 0, 1, 0); push(0, "start030", 0, 12'h030, 1, 0);
    for (int i = 1; i <= 30; i++) begin
      cyc(0, 0, 0, 1);
      if (i < 30) push(0, "count030", 0, to_bcd(30 - i), 1, 0);
      else        push(0, "reach000", 0, 12'h000, 0, 1);
    end
    cyc(0, 0, 0, 1); push(0, "done_tick", 0, 12'h000, 0, 1);
    cyc(0, 0, 0, 1); push(0, "done_tick2", 0, 12'h000, 0, 1);
    cyc(0, 0, 1, 0); push(0, "done_ack", 0, 12'h030, 0, 0);

    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0); push(0, "sel120", 3, 12'h120, 0, 0);
    cyc(0, 0, 1, 0); push(0, "start120", 3, 12'h120, 1, 0);
    for (int i = 1; i <= 21; i++) begin
      cyc(0, 0, 0, 1); push(0, "borrow", 3, to_bcd(120 - i), 1, 0);
    end
    cyc(0, 0, 1, 0); push(0, "pause099", 3, 12'h099, 0, 0);
    cyc(0, 1, 0, 0); push(0, "abort120", 3, 12'h120, 0, 0);
    cyc(0, 1, 0, 0); push(0, "back030", 0, 12'h030, 0, 0);

    cyc(0, 0, 1, 0); push(0, "run030", 0, 12'h030, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 0, 1); push(0, "run5", 0, to_bcd(30 - i), 1, 0);
    end
    cyc(0, 0, 1, 0); push(0, "pause025", 0, 12'h025, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1); push(0, "pause_hold", 0, 12'h025, 0, 0);
    end
    cyc(0, 0, 1, 0); push(0, "resume", 0, 12'h025, 1, 0);
    cyc(0, 0, 0, 1); push(0, "tick024", 0, 12'h024, 1, 0);
    cyc(0, 0, 1, 0); push(0, "pause024", 0, 12'h024, 0, 0);
    cyc(0, 1, 0, 0); push(0, "abort030", 0, 12'h030, 0, 0);

    cyc(0, 0, 1, 0); push(0, "run_again", 0, 12'h030, 1, 0);
    for (int i = 0; i < 29; i++) cyc(0, 0, 0, 1);
    push(0, "at001", 0, 12'h001, 1, 0);
    cyc(0, 0, 1, 1); push(0, "tick_start_done", 0, 12'h000, 0, 1);
    cyc(0, 1, 1, 0); push(0, "done_both", 0, 12'h030, 0, 0);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 0, 1);
    push(0, "done_again", 0, 12'h000, 0, 1);
    cyc(0, 1, 0, 0); push(0, "done_mode", 1, 12'h060, 0, 0);
    cyc(0, 1, 1, 0); push(0, "idle_both", 1, 12'h060, 1, 0);
    cyc(0, 1, 1, 0); push(0, "run_both", 1, 12'h060, 0, 0);
    cyc(0, 1, 1, 0); push(0, "pause_both", 1, 12'h060, 1, 0);

    cyc(0, 0, 1, 0); cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0); push(0, "sel090", 2, 12'h090, 0, 0);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 73; i++) cyc(0, 0, 0, 1);
    push(0, "at017", 2, 12'h017, 1, 0);
    cyc(1, 0, 0, 1); push(0, "mid_reset", 0, 12'h030, 0, 0);
    cyc(0, 0, 0, 0);

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (sb_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/preset_countdown_fsm.md
Name: preset_countdown_fsm

Overview:
- Parametrised successor to the two-mode 30 s/60 s selector.
- Cycles through NUM_MODES BCD presets on a mode button, then runs a start/pause countdown from the selected preset on a 1 Hz tick.
- Drives three BCD digits to the 7-segment scan logic.
- Inputs come from the debounce/one-pulse stage and the clock-divider tick.

Parameters:
- NUM_MODES, 4, number of selectable presets; legal range 2..4.
- PRESET_0, 12'h030, BCD preset for mode 0 ({hundreds, tens, ones}).
- PRESET_1, 12'h060, BCD preset for mode 1.
- PRESET_2, 12'h090, BCD preset for mode 2; ignored if NUM_MODES < 3.
- PRESET_3, 12'h120, BCD preset for mode 3; ignored if NUM_MODES < 4.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_p  input  1  synchronous, active-high reset.
- mode_pressed  input  1  one-cycle pulse: select next preset / abort.
- start_pressed  input  1  one-cycle pulse: start / pause / resume / acknowledge.
- tick  input  1  one-cycle enable at 1 Hz.
- mode_idx  output  2  current preset index.
- value_digit0  output  4  BCD ones.
- value_digit1  output  4  BCD tens.
- value_digit2  output  4  BCD hundreds.
- running  output  1  high in RUN.
- done  output  1  high in DONE.

Behaviour:
- **Outputs:** all registered; one-cycle latency from input pulse to output.
- **Reset (rst_p high at posedge, any state):**
  - state=IDLE, mode_idx=0, digits=PRESET_0, running=0, done=0.
  - Overrides all other inputs on that edge.
- **States:** IDLE, RUN, PAUSE, DONE.
- **IDLE:**
  - start_pressed with count != 000: go to RUN.
  - start_pressed with count == 000: go to DONE.
  - mode_pressed (without start): mode_idx=(mode_idx+1) mod NUM_MODES, wrapping NUM_MODES-1 to 0. Digits load the new preset on the same edge.
  - start_pressed and mode_pressed together: start wins, mode ignored.
  - tick ignored.
- **RUN:**
  - tick: BCD decrement by 1. Ones 0 becomes 9 with borrow to tens; tens 0 becomes 9 with borrow to hundreds.
  - If the decrement result is 000, go to DONE on the same edge.
  - start_pressed: go to PAUSE.
  - tick and start together: decrement applies, then go to PAUSE, unless the result is 000, in which case DONE wins.
  - mode_pressed ignored.
- **PAUSE:**
  - Digits hold; tick ignored.
  - start_pressed: go to RUN.
  - mode_pressed (without start): go to IDLE and reload the current mode's preset; mode_idx unchanged.
  - start and mode together: start wins.
- **DONE:**
  - Digits=000, done=1, tick ignored.
  - start_pressed: go to IDLE and reload the current preset.
  - mode_pressed: go to IDLE, advance mode_idx, load the new preset.
  - Both together: start wins.
- **Output encoding:** running=1 only in RUN; done=1 only in DONE; both 0 in IDLE and PAUSE.
- **Invariants:**
  - Digits are always valid BCD, 0..9 each.
  - The counter never underflows below 000.
  - Non-BCD preset parameters are a configuration error; behaviour undefined.
- **Unused modes:** for NUM_MODES < 4, indices >= NUM_MODES are unreachable.

Test Plan:
- **Reset:** pulse rst_p for 1 cycle -> mode_idx=0, digits (d2,d1,d0)=(0,3,0), running=0, done=0.
- **Mode cycling (NUM_MODES=4):** 4 mode pulses in IDLE -> digits 060, 090, 120, then 030 with mode_idx 1,2,3,0. With NUM_MODES=2 -> 060, 030.
- **Full countdown:** preset 030, start, 30 ticks -> 029 ... 001, then 000 with done=1 and running=0 on the cycle after the 30th tick. Extra ticks leave 000. A start pulse then returns to IDLE at 030.
- **Borrow chain:** preset 120, start, 1 tick -> 119; 20 ticks total -> 100; 21 ticks -> 099.
- **Pause and abort:**
  - Preset 030, start, 5 ticks -> 025.
  - start pulse -> running=0; 3 ticks -> still 025.
  - start pulse -> resume; 1 tick -> 024.
  - start pulse, then mode pulse -> IDLE at 030, mode_idx=0.
- **Simultaneous events and mid-run reset:**
  - At count 001 in RUN, assert tick+start together -> DONE, 000.
  - In IDLE, assert start+mode together -> RUN, mode_idx unchanged.
  - rst_p during RUN at 017 with mode_idx=2 -> next edge IDLE, 030, mode_idx=0.
